// File: rtl/mem_port_arbiter.sv
// Two-port arbiter and sequencer for a single-ported memory/IO target.
// Port 0 is instruction fetch and port 1 is load/store.
// One transaction is outstanding at a time: IDLE grants, ISSUE pulses dev_valid,
// WAIT collects operationOK (or times out) and RESP returns a one-cycle response.
module mem_port_arbiter #(
   parameter int               EXC_W       = 4,
   parameter int               TIMEOUT     = 16,
   parameter logic [EXC_W-1:0] EXC_TIMEOUT = 4'hF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [31:0]      req0_addr,
   input  logic [31:0]      req0_wdata,
   input  logic [1:0]       req0_width,
   input  logic             req0_isRead,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [31:0]      req1_addr,
   input  logic [31:0]      req1_wdata,
   input  logic [1:0]       req1_width,
   input  logic             req1_isRead,
   output logic             req1_ready,
   output logic             resp0_valid,
   output logic [31:0]      resp0_rdata,
   output logic [EXC_W-1:0] resp0_exc,
   output logic             resp1_valid,
   output logic [31:0]      resp1_rdata,
   output logic [EXC_W-1:0] resp1_exc,
   output logic [31:0]      dev_addr,
   output logic [31:0]      dev_wdata,
   output logic [1:0]       dev_width,
   output logic             dev_isRead,
   output logic             dev_valid,
   input  logic [31:0]      dev_rdata,
   input  logic             dev_ok,
   input  logic [EXC_W-1:0] dev_exc
);

   localparam int            TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic              r_lastGrant;
   logic              r_grant;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [1:0]        r_width;
   logic              r_isRead;
   logic [TW-1:0]     r_timer;
   logic [31:0]       r_rdata;
   logic [EXC_W-1:0]  r_exc;

   logic              w_accept;
   logic              w_grantPort;
   logic              w_timedOut;
   logic              w_respValid;

   // Round-robin pick: on a tie the port that was not served last wins.
   always_comb begin
      w_grantPort = 1'b0;
      if (req0_valid && req1_valid) begin
         w_grantPort = ~r_lastGrant;
      end else if (req1_valid) begin
         w_grantPort = 1'b1;
      end
      w_accept   = (r_state == ST_IDLE) && (req0_valid || req1_valid);
      w_timedOut = (r_timer == TIMER_MAX);
      req0_ready = w_accept && !w_grantPort;
      req1_ready = w_accept && w_grantPort;
   end

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic and the target/response outputs decoded from the state.
   always_comb begin
      w_nextState = r_state;
      dev_valid   = 1'b0;
      dev_addr    = '0;
      dev_wdata   = '0;
      dev_width   = '0;
      dev_isRead  = 1'b0;
      w_respValid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_nextState = ST_ISSUE;
         end
         ST_ISSUE: begin
            dev_valid   = 1'b1;
            w_nextState = (dev_exc != '0) ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            if (dev_ok || w_timedOut) w_nextState = ST_RESP;
         end
         ST_RESP: begin
            w_respValid = 1'b1;
            w_nextState = ST_IDLE;
         end
         default: w_nextState = ST_IDLE;
      endcase
      if (r_state != ST_IDLE) begin
         dev_addr   = r_addr;
         dev_wdata  = r_wdata;
         dev_width  = r_width;
         dev_isRead = r_isRead;
      end
      resp0_valid = w_respValid && !r_grant;
      resp1_valid = w_respValid && r_grant;
      resp0_rdata = resp0_valid ? r_rdata : '0;
      resp0_exc   = resp0_valid ? r_exc : '0;
      resp1_rdata = resp1_valid ? r_rdata : '0;
      resp1_exc   = resp1_valid ? r_exc : '0;
   end

   // Request latch, timeout counter and response capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lastGrant <= 1'b1;
         r_grant     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_width     <= '0;
         r_isRead    <= 1'b0;
         r_timer     <= '0;
         r_rdata     <= '0;
         r_exc       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_grant  <= w_grantPort;
                  r_addr   <= w_grantPort ? req1_addr : req0_addr;
                  r_wdata  <= w_grantPort ? req1_wdata : req0_wdata;
                  r_width  <= w_grantPort ? req1_width : req0_width;
                  r_isRead <= w_grantPort ? req1_isRead : req0_isRead;
                  r_rdata  <= '0;
                  r_exc    <= '0;
               end
            end
            ST_ISSUE: begin
               r_timer <= '0;
               if (dev_exc != '0) begin
                  r_exc   <= dev_exc;
                  r_rdata <= '0;
               end
            end
            ST_WAIT: begin
               if (dev_ok) begin
                  r_rdata <= r_isRead ? dev_rdata : 32'h0;
                  r_exc   <= '0;
               end else if (w_timedOut) begin
                  r_exc   <= EXC_TIMEOUT;
                  r_rdata <= '0;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            ST_RESP: begin
               r_lastGrant <= r_grant;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: the bench plays both requesters and
// the memory target, and checks grant, issue pulse, response timing and data.
module tb_mem_port_arbiter;

   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  width;
      logic        isRead;
   } req_t;

   typedef struct {
      logic [1:0]  mask;
      req_t        r0;
      req_t        r1;
      logic [31:0] tRdata;
      logic [3:0]  tExc;
      int          okDelay;
      int          expG;
      int          expLat;
      logic [31:0] expRdata;
      logic [3:0]  expExc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
   logic [1:0]  req0_width, req1_width;
   logic        req0_isRead, req1_isRead;
   logic        req0_ready, req1_ready;
   logic        resp0_valid, resp1_valid;
   logic [31:0] resp0_rdata, resp1_rdata;
   logic [3:0]  resp0_exc, resp1_exc;
   logic [31:0] dev_addr, dev_wdata, dev_rdata;
   logic [1:0]  dev_width;
   logic        dev_isRead, dev_valid, dev_ok;
   logic [3:0]  dev_exc;
   logic [3:0]  tgtExc;
   logic [255:0] allOuts;

   int nTests = 0;
   int nFail  = 0;
   int lastGrantM = 1;
   vec_t vecs[$];

   mem_port_arbiter #(.EXC_W(4), .TIMEOUT(TIMEOUT), .EXC_TIMEOUT(4'hF)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_width(req0_width), .req0_isRead(req0_isRead), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_width(req1_width), .req1_isRead(req1_isRead), .req1_ready(req1_ready),
      .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_exc(resp0_exc),
      .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_exc(resp1_exc),
      .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_width(dev_width),
      .dev_isRead(dev_isRead), .dev_valid(dev_valid), .dev_rdata(dev_rdata),
      .dev_ok(dev_ok), .dev_exc(dev_exc)
   );

   always #5 clk = ~clk;

   // The target reports an exception combinationally while it sees inputValid.
   assign dev_exc = dev_valid ? tgtExc : 4'h0;

   assign allOuts = {req0_ready, req1_ready, resp0_valid, resp0_rdata, resp0_exc,
                     resp1_valid, resp1_rdata, resp1_exc, dev_addr, dev_wdata,
                     dev_width, dev_isRead, dev_valid};

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [255:0] act,
                              input logic [255:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic req_t mkReq(input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] w, input logic rd);
      req_t r;
      r.addr = a; r.wdata = d; r.width = w; r.isRead = rd;
      return r;
   endfunction

   function automatic void addVec(input logic [1:0] m, input req_t r0, input req_t r1,
                                  input logic [31:0] tRd, input logic [3:0] tEx,
                                  input int okD, input int g, input int lat,
                                  input logic [31:0] rd, input logic [3:0] ex);
      vec_t v;
      v.mask = m; v.r0 = r0; v.r1 = r1; v.tRdata = tRd; v.tExc = tEx;
      v.okDelay = okD; v.expG = g; v.expLat = lat; v.expRdata = rd; v.expExc = ex;
      vecs.push_back(v);
   endfunction

   // Reference model: grant by round-robin, latency counted from acceptance.
   // dev_valid is one cycle after accept; dev_ok okDelay cycles after dev_valid
   // counts only if it falls in the TIMEOUT-cycle waiting window.
   function automatic void refModel(input logic [1:0] m, input req_t r0, input req_t r1,
                                    input logic [31:0] tRd, input logic [3:0] tEx,
                                    input int okD, output int g, output int lat,
                                    output logic [31:0] rd, output logic [3:0] ex);
      req_t r;
      if (m == 2'b11) g = (lastGrantM == 0) ? 1 : 0;
      else            g = m[0] ? 0 : 1;
      r = (g == 1) ? r1 : r0;
      if (tEx != 4'h0) begin
         lat = 2; rd = 32'h0; ex = tEx;
      end else if (okD >= 1 && okD <= TIMEOUT) begin
         lat = 2 + okD; rd = r.isRead ? tRd : 32'h0; ex = 4'h0;
      end else begin
         lat = 2 + TIMEOUT; rd = 32'h0; ex = 4'hF;
      end
   endfunction

   // Runs one transaction from the IDLE cycle to its response and checks it.
   task automatic applyStimulus(input string tag, input logic [1:0] mask,
                                input req_t r0, input req_t r1,
                                input logic [31:0] tRdata, input logic [3:0] tExc,
                                input int okDelay, input int expG, input int expLat,
                                input logic [31:0] expRdata, input logic [3:0] expExc);
      logic [1:0]  readyAt0 = 2'b00;
      int          dvCount = 0;
      int          dvCycle = -1;
      req_t        dvSeen = '0;
      int          respCycle = -1;
      int          respOther = 0;
      logic [31:0] respRd = '0;
      logic [3:0]  respEx = '0;
      int          viol = 0;
      bit          done = 0;
      req_t        expReq;
      expReq = (expG == 1) ? r1 : r0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         req0_valid  = mask[0] && (c == 0 || expG != 0);
         req1_valid  = mask[1] && (c == 0 || expG != 1);
         req0_addr   = r0.addr; req0_wdata = r0.wdata;
         req0_width  = r0.width; req0_isRead = r0.isRead;
         req1_addr   = r1.addr; req1_wdata = r1.wdata;
         req1_width  = r1.width; req1_isRead = r1.isRead;
         dev_ok      = (c == 1 + okDelay);
         dev_rdata   = tRdata;
         tgtExc      = tExc;
         #1;
         if (c == 0) readyAt0 = {req1_ready, req0_ready};
         else if (req0_ready || req1_ready) viol++;
         if (req0_ready && req1_ready) viol++;
         if (dev_valid) begin
            dvCount++;
            if (dvCycle < 0) begin
               dvCycle = c;
               dvSeen  = {dev_addr, dev_wdata, dev_width, dev_isRead};
            end
         end
         if (!resp0_valid && (resp0_rdata != 0 || resp0_exc != 0)) viol++;
         if (!resp1_valid && (resp1_rdata != 0 || resp1_exc != 0)) viol++;
         if ((expG == 1) ? resp0_valid : resp1_valid) respOther++;
         if ((expG == 1) ? resp1_valid : resp0_valid) begin
            respCycle = c;
            respRd    = (expG == 1) ? resp1_rdata : resp0_rdata;
            respEx    = (expG == 1) ? resp1_exc : resp0_exc;
            done      = 1;
         end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      dev_ok     = 1'b0;
      tgtExc     = 4'h0;
      checkOutput({tag, " ready"}, readyAt0, (expG == 1) ? 2'b10 : 2'b01);
      checkOutput({tag, " devValidCount"}, dvCount, 1);
      checkOutput({tag, " devValidCycle"}, dvCycle, 1);
      checkOutput({tag, " devFields"}, dvSeen, expReq);
      checkOutput({tag, " respCycle"}, respCycle, expLat);
      checkOutput({tag, " respOtherPort"}, respOther, 0);
      checkOutput({tag, " respRdata"}, respRd, expRdata);
      checkOutput({tag, " respExc"}, respEx, expExc);
      checkOutput({tag, " protocol"}, viol, 0);
      lastGrantM = expG;
   endtask

   initial begin
      int          g, lat, quiet;
      logic [31:0] rd;
      logic [3:0]  ex;
      logic [1:0]  m;
      req_t        a, b;
      logic [31:0] tRd;
      logic [3:0]  tEx;
      int          okD;

      rst = 1'b1;
      req0_valid = 0; req1_valid = 0;
      req0_addr = 0; req0_wdata = 0; req0_width = 0; req0_isRead = 0;
      req1_addr = 0; req1_wdata = 0; req1_width = 0; req1_isRead = 0;
      dev_rdata = 0; dev_ok = 0; tgtExc = 0;
      repeat (3) @(negedge clk);
      #1 checkOutput("reset outputs", allOuts, 256'h0);
      rst = 1'b0;

      a = mkReq(32'h40, 32'h0, 2'd2, 1'b1);
      b = mkReq(32'h140, 32'h0, 2'd2, 1'b1);
      addVec(2'b01, mkReq(32'h0, 32'h0, 2'd2, 1'b1), '0, 32'hDEADBEEF, 4'h0, 1, 0, 3, 32'hDEADBEEF, 4'h0);
      addVec(2'b11, a, b, 32'h11111111, 4'h0, 1, 1, 3, 32'h11111111, 4'h0);
      addVec(2'b11, a, b, 32'h22222222, 4'h0, 1, 0, 3, 32'h22222222, 4'h0);
      addVec(2'b11, a, b, 32'h33333333, 4'h0, 1, 1, 3, 32'h33333333, 4'h0);
      addVec(2'b10, '0, mkReq(32'h0, 32'h12, 2'd2, 1'b0), 32'hCAFEF00D, 4'h0, 1, 1, 3, 32'h0, 4'h0);
      addVec(2'b10, '0, mkReq(32'h8, 32'h0, 2'd2, 1'b1), 32'h55555555, 4'h5, 1, 1, 2, 32'h0, 4'h5);
      addVec(2'b01, mkReq(32'h10, 32'h0, 2'd2, 1'b1), '0, 32'h66666666, 4'h0, 99, 0, 18, 32'h0, 4'hF);
      addVec(2'b01, mkReq(32'h14, 32'h0, 2'd1, 1'b1), '0, 32'h77777777, 4'h0, 16, 0, 18, 32'h77777777, 4'h0);
      addVec(2'b10, '0, mkReq(32'h18, 32'hAB, 2'd0, 1'b0), 32'h88888888, 4'h0, 17, 1, 18, 32'h0, 4'hF);
      addVec(2'b01, mkReq(32'h1C, 32'h0, 2'd2, 1'b1), '0, 32'h12345678, 4'h0, 0, 0, 18, 32'h0, 4'hF);
      addVec(2'b01, mkReq(32'h20, 32'h0, 2'd2, 1'b1), '0, 32'h99999999, 4'h0, 3, 0, 5, 32'h99999999, 4'h0);

      foreach (vecs[i]) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].mask, vecs[i].r0, vecs[i].r1,
                       vecs[i].tRdata, vecs[i].tExc, vecs[i].okDelay, vecs[i].expG,
                       vecs[i].expLat, vecs[i].expRdata, vecs[i].expExc);
      end

      // Reset while the arbiter is waiting on the target.
      @(negedge clk);
      req0_valid = 1'b1; req0_addr = 32'h24; req0_isRead = 1'b1; dev_ok = 1'b0;
      #1 checkOutput("midrst accept", req0_ready, 1'b1);
      @(negedge clk);
      req0_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1 checkOutput("midrst outputs", allOuts, 256'h0);
      rst = 1'b0;
      lastGrantM = 1;
      quiet = 0;
      repeat (20) begin
         @(negedge clk);
         #1;
         if (resp0_valid || resp1_valid || dev_valid) quiet++;
      end
      checkOutput("midrst quiet", quiet, 0);
      applyStimulus("postrst", 2'b11, a, b, 32'hA5A5A5A5, 4'h0, 1, 0, 3, 32'hA5A5A5A5, 4'h0);

      // Randomised transactions against the reference model.
      for (int n = 0; n < 30; n++) begin
         m   = 2'($urandom_range(1, 3));
         a   = mkReq($urandom, $urandom, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
         b   = mkReq($urandom, $urandom, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
         tRd = $urandom;
         tEx = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         okD = $urandom_range(0, 20);
         refModel(m, a, b, tRd, tEx, okD, g, lat, rd, ex);
         applyStimulus($sformatf("rand%0d", n), m, a, b, tRd, tEx, okD, g, lat, rd, ex);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
